// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer for the pipelined MIPS core: computes mult/div results
// at accept, holds them for a fixed latency, then commits to the HI/LO registers it owns.
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cancel,
    output logic        Busy,
    output logic        BusyNext,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic [31:0] phi_r;
    logic [31:0] plo_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        skip_r;
    logic        busy_r;

    logic        accept_s;
    logic        long_op_s;
    logic        is_div_s;
    logic [63:0] prod_s;
    logic [31:0] ua_s;
    logic [31:0] ub_s;
    logic [31:0] uq_s;
    logic [31:0] ur_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;

    // Accept qualification and the stall-facing busy look-ahead
    always_comb begin
        long_op_s = (MDUOp <= 3'd3);
        is_div_s  = (MDUOp == 3'd2) || (MDUOp == 3'd3);
        accept_s  = Start & ~Cancel & ~busy_r & (MDUOp <= 3'd5);
        BusyNext  = busy_r | (Start & ~Cancel & long_op_s);
    end

    // Result datapath; signed divide works on magnitudes so the overflow case needs no special handling
    always_comb begin
        prod_s   = 64'd0;
        ua_s     = A;
        ub_s     = B;
        uq_s     = 32'd0;
        ur_s     = 32'd0;
        res_hi_s = 32'd0;
        res_lo_s = 32'd0;
        case (MDUOp)
            3'd0: begin
                prod_s   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
                res_hi_s = prod_s[63:32];
                res_lo_s = prod_s[31:0];
            end
            3'd1: begin
                prod_s   = {32'd0, A} * {32'd0, B};
                res_hi_s = prod_s[63:32];
                res_lo_s = prod_s[31:0];
            end
            3'd2: begin
                ua_s = A[31] ? (~A + 32'd1) : A;
                ub_s = B[31] ? (~B + 32'd1) : B;
                if (ub_s != 32'd0) begin
                    uq_s = ua_s / ub_s;
                    ur_s = ua_s % ub_s;
                end else begin
                    uq_s = 32'd0;
                    ur_s = 32'd0;
                end
                res_lo_s = (A[31] ^ B[31]) ? (~uq_s + 32'd1) : uq_s;
                res_hi_s = A[31] ? (~ur_s + 32'd1) : ur_s;
            end
            3'd3: begin
                if (B != 32'd0) begin
                    res_lo_s = A / B;
                    res_hi_s = A % B;
                end else begin
                    res_lo_s = 32'd0;
                    res_hi_s = 32'd0;
                end
            end
            default: begin
                res_hi_s = 32'd0;
                res_lo_s = 32'd0;
            end
        endcase
    end

    // Sequencer FSM, pending results and the architectural HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            phi_r   <= 32'd0;
            plo_r   <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            skip_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (long_op_s) begin
                            phi_r   <= res_hi_s;
                            plo_r   <= res_lo_s;
                            skip_r  <= is_div_s & (B == 32'd0);
                            cnt_r   <= is_div_s ? DIV_CNT : MULT_CNT;
                            state_r <= RUN;
                            busy_r  <= 1'b1;
                        end else if (MDUOp == 3'd4) begin
                            hi_r <= A;
                        end else begin
                            lo_r <= A;
                        end
                    end
                end
                RUN: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        if (!skip_r) begin
                            hi_r <= phi_r;
                            lo_r <= plo_r;
                        end
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy = busy_r;
    assign HI   = hi_r;
    assign LO   = lo_r;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer: latency, results, mthi/mtlo,
// cancel, reserved ops, start-while-busy and reset mid-operation.
module tb_mdu_sequencer;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cancel;
    logic        Busy;
    logic        BusyNext;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .Start   (Start),
        .MDUOp   (MDUOp),
        .A       (A),
        .B       (B),
        .Cancel  (Cancel),
        .Busy    (Busy),
        .BusyNext(BusyNext),
        .HI      (HI),
        .LO      (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; accepts in this cycle T and ends at the negedge of T+n+1.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input bit noise);
        Start = 1'b1; MDUOp = op; A = a; B = b; Cancel = 1'b0;
        #1 check_val({tag, " busynext_T"}, {31'd0, BusyNext}, 32'd1);
        @(posedge clk);
        #1 Start = 1'b0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            check_val({tag, " busy"}, {31'd0, Busy}, 32'd1);
            check_val({tag, " busynext"}, {31'd0, BusyNext}, 32'd1);
            check_val({tag, " hi_hold"}, HI, m_hi);
            check_val({tag, " lo_hold"}, LO, m_lo);
            if (noise) begin
                Start = (i < n); MDUOp = 3'd0; A = 32'd3; B = 32'd3;
            end
        end
        @(negedge clk);
        check_val({tag, " busy_end"}, {31'd0, Busy}, 32'd0);
        check_val({tag, " hi"}, HI, exp_hi);
        check_val({tag, " lo"}, LO, exp_lo);
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; MDUOp = 3'd0; A = 32'd0; B = 32'd0; Cancel = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_val("rst busy", {31'd0, Busy}, 32'd0);
        check_val("rst busynext", {31'd0, BusyNext}, 32'd0);
        check_val("rst hi", HI, 32'd0);
        check_val("rst lo", LO, 32'd0);

        run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0);
        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("divu_zero", 3'd3, 32'd7, 32'd0, 10, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("divu", 3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b0);

        // mthi then mtlo on consecutive cycles
        Start = 1'b1; MDUOp = 3'd4; A = 32'h1234_5678;
        #1 check_val("mthi busynext", {31'd0, BusyNext}, 32'd0);
        @(posedge clk);
        #1 MDUOp = 3'd5; A = 32'h9ABC_DEF0;
        check_val("mthi hi", HI, 32'h1234_5678);
        check_val("mthi lo", LO, 32'd14);
        check_val("mthi busy", {31'd0, Busy}, 32'd0);
        check_val("mtlo busynext", {31'd0, BusyNext}, 32'd0);
        @(posedge clk);
        #1 Start = 1'b0;
        check_val("mtlo hi", HI, 32'h1234_5678);
        check_val("mtlo lo", LO, 32'h9ABC_DEF0);
        check_val("mtlo busy", {31'd0, Busy}, 32'd0);
        m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;

        // Cancelled mult
        @(negedge clk);
        Start = 1'b1; MDUOp = 3'd0; A = 32'd9; B = 32'd9; Cancel = 1'b1;
        #1 check_val("cancel busynext", {31'd0, BusyNext}, 32'd0);
        @(posedge clk);
        #1 Start = 1'b0; Cancel = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val("cancel busy", {31'd0, Busy}, 32'd0);
        end
        check_val("cancel hi", HI, m_hi);
        check_val("cancel lo", LO, m_lo);

        // Reserved op writes nothing
        Start = 1'b1; MDUOp = 3'd6; A = 32'hDEAD_BEEF; B = 32'd1;
        #1 check_val("rsvd busynext", {31'd0, BusyNext}, 32'd0);
        @(posedge clk);
        #1 Start = 1'b0;
        @(negedge clk);
        check_val("rsvd busy", {31'd0, Busy}, 32'd0);
        check_val("rsvd hi", HI, m_hi);
        check_val("rsvd lo", LO, m_lo);

        // Start held during div busy is ignored; back-to-back accept at T+N+1
        run_op("div_noisy", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
        run_op("b2b_mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);

        // Reset in the third busy cycle of a div abandons it
        Start = 1'b1; MDUOp = 3'd3; A = 32'd50; B = 32'd5;
        @(posedge clk);
        #1 Start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check_val("rstmid busy", {31'd0, Busy}, 32'd1);
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_val("rstmid busy_after", {31'd0, Busy}, 32'd0);
        check_val("rstmid hi", HI, 32'd0);
        check_val("rstmid lo", LO, 32'd0);
        repeat (12) @(negedge clk);
        check_val("rstmid no_commit_hi", HI, 32'd0);
        check_val("rstmid no_commit_lo", LO, 32'd0);
        check_val("rstmid idle", {31'd0, Busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle multiply/divide unit sequencer for the pipelined MIPS core: accepts mult/multu/div/divu/mthi/mtlo from the E stage, runs a fixed-latency operation and owns the HI/LO registers. It produces the busy indication consumed by the hazard/stall logic, so that mfhi/mflo and further MDU ops hold in D while an operation is in flight. It is the single owner of HI/LO; no other block writes them.

## Interface

- MULT_CYCLES, default 5: busy cycles for mult/multu (legal 1..15).
- DIV_CYCLES, default 10: busy cycles for div/divu (legal 1..15).

- clk  in  1  core clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- Start  in  1  E-stage instruction is an MDU write op (qualifies MDUOp/A/B).
- MDUOp  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved (no-op).
- A  in  32  rs operand (dividend / multiplicand / mthi-mtlo source).
- B  in  32  rt operand (divisor / multiplier).
- Cancel  in  1  E-stage instruction is being flushed (exception/interrupt); suppresses Start this cycle.
- Busy  out  1  registered; high while a mult/div is in flight.
- BusyNext  out  1  Busy OR accepted mult/div start this cycle; feeds the stall controller's MDU-busy input.
- HI  out  32  HI register.
- LO  out  32  LO register.

## Operation

- States: IDLE, RUN. Internal: 4-bit down-counter Cnt, 32-bit pending registers PHi/PLo, flag Skip (suppress commit).
- Accept = Start & ~Cancel & ~Busy & (MDUOp ≤ 5).
- IDLE, Accept with MDUOp 0..3: compute result from A/B, latch into PHi/PLo; Cnt ← MULT_CYCLES or DIV_CYCLES; go RUN; Busy ← 1.
- IDLE, Accept with mthi/mtlo: HI ← A (or LO ← A) at this edge; stay IDLE; Busy stays 0.
- RUN: Cnt decrements each cycle; on cycle where Cnt==1: HI ← PHi, LO ← PLo (unless Skip), go IDLE, Busy ← 0.
- Start while Busy: ignored entirely (stall controller guarantees it cannot occur; bench checks it has no effect).
- Reserved MDUOp 6/7: no state change.
- mult: signed 32×32 → 64; HI = bits 63:32, LO = bits 31:0. multu: unsigned.
- div: signed; LO = quotient truncated toward zero, HI = remainder with sign of dividend. 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0x00000000.
- divu: unsigned quotient/remainder.
- Divide by zero (B == 0, div or divu): full busy latency still taken; Skip set; HI/LO unchanged.
- Cancel only affects the cycle it is asserted; an op already in RUN always completes.
- reset: state IDLE, Cnt 0, Busy 0, HI 0, LO 0, PHi/PLo 0, Skip 0; reset mid-RUN abandons the op with no commit.

## Timing

- Cycle T: Accept of mult/div. BusyNext = 1 in T (combinational). Busy = 1 in T+1 .. T+N (N = MULT_CYCLES or DIV_CYCLES).
- HI/LO new value visible in T+N+1, same cycle Busy first reads 0; mfhi in D may issue from T+N+1.
- Back-to-back: new Accept legal in T+N+1.
- mthi/mtlo accepted in T: HI/LO updated, visible in T+1; Busy/BusyNext never assert.
- BusyNext = Busy | (Start & ~Cancel & MDUOp ∈ {0..3}); no dependence on HI/LO.
- No combinational path from A/B to Busy, HI or LO.

## Test plan

- Reset then idle: reset high 2 cycles -> Busy=0, BusyNext=0, HI=0, LO=0.
- mult A=0xFFFFFFFE (−2), B=3 at T -> BusyNext=1 at T, Busy=1 for T+1..T+5, at T+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA, Busy=0; multu same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (−7), B=2 -> Busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0; divu 7/0 -> 10 busy cycles, HI/LO unchanged.
- mthi A=0x12345678 then mtlo A=0x9ABCDEF0 on consecutive cycles -> HI/LO updated one cycle after each, Busy never 1; Start (mult) with Cancel=1 -> no Busy, HI/LO unchanged.
- Start mult during Busy of a div -> ignored, div result committed unchanged at expected cycle; Accept at T+N+1 starts normally.
- reset asserted at 3rd busy cycle of div -> next cycle Busy=0, HI=LO=0, no later commit.
